// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Upstream fetch stage of the RV32I core. It holds the PC and fetches one
//   instruction at a time over a req/ack instruction-memory port. Each
//   instruction is presented to the Controller for one execute cycle, or
//   longer while stall is high. The unit then commits the next PC that the
//   Controller's PCSrc selects.
//
// Ports
//   clk          in   rising-edge system clock
//   rst_n        in   synchronous reset, active-low
//   pc_src       in   2   00 PC+4, 01 JALR (alu_res), 10 PC+imm_ext, 11 PC+4
//   imm_ext      in   XLEN sign-extended immediate
//   alu_res      in   XLEN JALR target (rs1+imm)
//   stall        in   hold the current instruction in EXEC
//   imem_ack     in   imem_rdata valid this cycle
//   imem_rdata   in   32  instruction word
//   imem_req     out  fetch request, held until imem_ack
//   imem_addr    out  XLEN fetch address (= pc)
//   instr        out  32  latched instruction register
//   opc/f3/f7    out  decode fields of instr
//   instr_valid  out  instr is executing this cycle
//   pc           out  XLEN PC of instr
//   pc_plus4     out  XLEN link value pc+4
//   misalign     out  sticky: committed target was misaligned, unit halted
//   retired      out  32  count of committed instructions
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] alu_res,
  input  logic            stall,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  output logic [31:0]     instr,
  output logic [6:0]      opc,
  output logic [2:0]      f3,
  output logic [6:0]      f7,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign,
  output logic [31:0]     retired
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            misalign_q, misalign_d;
  logic [31:0]     retired_q, retired_d;
  logic [XLEN-1:0] next_pc;

  // PC selection; all additions wrap modulo 2^XLEN without any flag.
  // The reserved encoding 11 falls back to sequential flow.
  function automatic logic [XLEN-1:0] calc_next_pc(
    input logic [1:0]      src,
    input logic [XLEN-1:0] cur_pc,
    input logic [XLEN-1:0] imm,
    input logic [XLEN-1:0] alu
  );
    logic [XLEN-1:0] res;
    case (src)
      2'b01:   res = {alu[XLEN-1:1], 1'b0};
      2'b10:   res = cur_pc + imm;
      default: res = cur_pc + XLEN'(4);
    endcase
    return res;
  endfunction

  assign next_pc = calc_next_pc(pc_src, pc_q, imm_ext, alu_res);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= NOP;
      misalign_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      misalign_q <= misalign_d;
      retired_q  <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    misalign_d = misalign_q;
    retired_d  = retired_q;
    case (state_q)
      // One bubble after reset release; an ack here is never sampled.
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          // A misaligned target still counts as a retired instruction,
          // but the PC stays on the offending instruction.
          retired_d = retired_q + 32'd1;
          if (next_pc[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = S_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = S_FETCH;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req    = (state_q == S_FETCH);
  assign instr_valid = (state_q == S_EXEC);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + XLEN'(4);
  assign instr       = instr_q;
  assign opc         = instr_q[6:0];
  assign f3          = instr_q[14:12];
  assign f7          = instr_q[31:25];
  assign misalign    = misalign_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pc_src;
  logic [31:0] imm_ext, alu_res;
  logic        stall, imem_ack;
  logic [31:0] imem_rdata;

  logic        imem_req, instr_valid, misalign;
  logic [31:0] imem_addr, instr, pc, pc_plus4, retired;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;

  logic        w_req, w_valid, w_mis;
  logic [31:0] w_addr, w_instr, w_pc, w_pc4, w_ret;
  logic [6:0]  w_opc, w_f7;
  logic [2:0]  w_f3;

  int total = 0;
  int bad   = 0;

  // Transaction-level expectations
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ret;
  logic        m_halt;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .imm_ext(imm_ext),
    .alu_res(alu_res), .stall(stall), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .imem_req(imem_req), .imem_addr(imem_addr),
    .instr(instr), .opc(opc), .f3(f3), .f7(f7), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4), .misalign(misalign), .retired(retired)
  );

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .imm_ext(imm_ext),
    .alu_res(alu_res), .stall(stall), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .imem_req(w_req), .imem_addr(w_addr),
    .instr(w_instr), .opc(w_opc), .f3(w_f3), .f7(w_f7), .instr_valid(w_valid),
    .pc(w_pc), .pc_plus4(w_pc4), .misalign(w_mis), .retired(w_ret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_exec(input string tag);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    chk({tag, "_req"},   32'(imem_req),    32'd0);
    chk({tag, "_instr"}, instr,            m_instr);
    chk({tag, "_opc"},   32'(opc),         32'(m_instr[6:0]));
    chk({tag, "_f3"},    32'(f3),          32'(m_instr[14:12]));
    chk({tag, "_f7"},    32'(f7),          32'(m_instr[31:25]));
    chk({tag, "_pc"},    pc,               m_pc);
    chk({tag, "_pc4"},   pc_plus4,         m_pc + 32'd4);
    chk({tag, "_ret"},   retired,          m_ret);
  endtask

  // Expects the unit to be requesting; acks after 'waits' idle cycles.
  task automatic do_fetch(input int waits, input logic [31:0] rd);
    for (int i = 0; i < waits; i++) begin
      chk("fetch_req",   32'(imem_req),    32'd1);
      chk("fetch_addr",  imem_addr,        m_pc);
      chk("fetch_valid", 32'(instr_valid), 32'd0);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      stall      = 1'($urandom);
      tick();
    end
    chk("fetch_req",  32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr,     m_pc);
    imem_ack   = 1'b1;
    imem_rdata = rd;
    tick();
    m_instr  = rd;
    imem_ack = 1'b0;
  endtask

  // Holds EXEC for 'stalls' cycles, then commits with the given PCSrc.
  task automatic do_exec(input int stalls, input logic [1:0] src,
                         input logic [31:0] imm, input logic [31:0] alu);
    logic [31:0] tgt;
    for (int i = 0; i < stalls; i++) begin
      chk_exec("stall");
      stall      = 1'b1;
      pc_src     = 2'($urandom);
      imm_ext    = $urandom;
      alu_res    = $urandom;
      imem_ack   = 1'($urandom);
      imem_rdata = $urandom;
      tick();
    end
    chk_exec("exec");
    stall    = 1'b0;
    pc_src   = src;
    imm_ext  = imm;
    alu_res  = alu;
    imem_ack = 1'($urandom);
    tick();
    imem_ack = 1'b0;
    stall    = 1'($urandom);
    if (src == 2'b01)      tgt = alu & ~32'd1;
    else if (src == 2'b10) tgt = m_pc + imm;
    else                   tgt = m_pc + 32'd4;
    m_ret = m_ret + 32'd1;
    if (tgt % 4 != 0) m_halt = 1'b1;
    else              m_pc   = tgt;
    chk("post_ret", retired, m_ret);
    chk("post_pc",  pc,      m_pc);
    if (m_halt) begin
      chk("post_mis",   32'(misalign),    32'd1);
      chk("post_req",   32'(imem_req),    32'd0);
      chk("post_valid", 32'(instr_valid), 32'd0);
    end else begin
      chk("post_mis",   32'(misalign),    32'd0);
      chk("post_req",   32'(imem_req),    32'd1);
      chk("post_addr",  imem_addr,        m_pc);
      chk("post_valid", 32'(instr_valid), 32'd0);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    imem_ack = 1'b1;
    tick();
    tick();
    rst_n    = 1'b1;
    m_pc     = 32'h0;
    m_instr  = 32'h0000_0013;
    m_ret    = 32'h0;
    m_halt   = 1'b0;
  endtask

  initial begin
    int          waits, stalls, sel;
    logic [1:0]  src;
    logic [31:0] imm, alu;

    rst_n = 1'b0; pc_src = 2'b00; imm_ext = '0; alu_res = '0;
    stall = 1'b0; imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);

    // Reset, with ack held high through reset and the idle bubble
    do_reset();
    chk("rst_req",   32'(imem_req),    32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc",    pc,               32'h0);
    chk("rst_instr", instr,            32'h0000_0013);
    chk("rst_ret",   retired,          32'h0);
    chk("rst_mis",   32'(misalign),    32'd0);
    chk("rst_wpc",   w_pc,             32'hFFFF_FFFC);
    tick();
    imem_ack = 1'b0;
    chk("idle_instr", instr,           32'h0000_0013);
    chk("fetch1_req", 32'(imem_req),   32'd1);
    chk("fetch1_addr", imem_addr,      32'h0);
    chk("wrap_addr0", w_addr,          32'hFFFF_FFFC);

    // Sequential zero-wait addi; wrap instance runs in lockstep
    do_fetch(0, 32'h0050_0093);
    chk("seq_opc", 32'(opc), 32'h13);
    chk("seq_f3",  32'(f3),  32'h0);
    do_exec(0, 2'b00, 32'h0, 32'h0);
    chk("wrap_addr1", w_addr,        32'h0);
    chk("wrap_req",   32'(w_req),    32'd1);
    chk("wrap_mis",   32'(w_mis),    32'd0);
    do_fetch(0, 32'h0050_0093);
    do_exec(0, 2'b00, 32'h0, 32'h0);
    chk("seq_pc8", pc, 32'h8);

    // Wait states and stall
    do_fetch(3, $urandom);
    do_exec(2, 2'b00, 32'h0, 32'h0);

    // Branch backwards from 0x10
    do_fetch(1, $urandom);
    do_exec(0, 2'b11, 32'h0, 32'h0);
    chk("br_pc10", pc, 32'h10);
    do_fetch(0, $urandom);
    do_exec(0, 2'b10, 32'hFFFF_FFF8, 32'h0);
    chk("br_addr8", imem_addr, 32'h8);

    // Randomized aligned traffic
    for (int n = 0; n < 40; n++) begin
      waits  = $urandom_range(0, 3);
      stalls = $urandom_range(0, 2);
      sel    = $urandom_range(0, 3);
      src    = 2'(sel);
      imm    = $urandom & 32'hFFFF_FFFC;
      alu    = $urandom & ~32'h2;
      do_fetch(waits, $urandom);
      do_exec(stalls, src, imm, alu);
    end

    // PC wrap at the top of the address space
    do_fetch(0, $urandom);
    do_exec(0, 2'b01, 32'h0, 32'hFFFF_FFFD);
    chk("wrap_top", pc, 32'hFFFF_FFFC);
    do_fetch(0, $urandom);
    do_exec(0, 2'b00, 32'h0, 32'h0);
    chk("wrap_zero", imem_addr, 32'h0);

    // JALR to misaligned target halts
    do_fetch(0, $urandom);
    do_exec(0, 2'b01, 32'h0, 32'h0000_0103);
    for (int i = 0; i < 5; i++) begin
      imem_ack = 1'($urandom);
      stall    = 1'($urandom);
      tick();
      chk("halt_req",   32'(imem_req),    32'd0);
      chk("halt_valid", 32'(instr_valid), 32'd0);
      chk("halt_mis",   32'(misalign),    32'd1);
      chk("halt_ret",   retired,          m_ret);
    end

    // Reset mid-FETCH with ack on the same edge
    do_reset();
    tick();
    chk("r2_req", 32'(imem_req), 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    rst_n      = 1'b0;
    tick();
    rst_n    = 1'b1;
    imem_ack = 1'b0;
    chk("r2_instr", instr,         32'h0000_0013);
    chk("r2_pc",    pc,            32'h0);
    chk("r2_ret",   retired,       32'h0);
    chk("r2_mis",   32'(misalign), 32'd0);
    chk("r2_req0",  32'(imem_req), 32'd0);
    tick();
    do_fetch(0, 32'h0050_0093);
    do_exec(1, 2'b00, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
